mem_bus_ram_slave: RTL and testbench

Memory-mapped RAM responder on the core's `mem_bus`, the slave end that instruction/data masters talk to. It decodes its address window, accepts one request at a time, applies a configurable number of wait states signalled through `busy`, then completes each transfer with a one-cycle `ack`. Byte-enabled writes and word reads are supported. It sits behind the core (or behind a bus decoder) as data/program RAM.

---
 rtl/mem_bus_ram_slave_pkg.sv | 18 +
 rtl/mem_bus.sv | 16 +
 rtl/mem_bus_ram_array.sv | 31 +++
 rtl/mem_bus_ram_slave.sv | 90 +++++++++
 tb/tb_mem_bus_ram_slave.sv | 219 +++++++++++++++++++++
 5 files changed

// File: rtl/mem_bus_ram_slave_pkg.sv
// Shared types and helpers for the mem_bus RAM responder.
package pck_mem_bus_ram;

  typedef enum logic [1:0] {IDLE, WAIT, ACK} ram_state_t;

  localparam int RAM_WAIT_MAX = 15;
  localparam int RAM_CNT_W    = $clog2(RAM_WAIT_MAX + 1);

  // True when addr falls inside the 4*2^depth_log2 byte window starting at base.
  function automatic logic in_window(input logic [31:0] addr,
                                     input logic [31:0] base,
                                     input int          depth_log2);
    logic [31:0] offset;
    offset = addr - base;
    return (offset >> (depth_log2 + 2)) == 32'd0;
  endfunction

endpackage

// File: rtl/mem_bus.sv
// Word-wide memory bus between masters (core) and slaves (RAM, peripherals).
interface mem_bus;
  logic [31:0] addr;
  logic [3:0]  be;
  logic        wr_en;
  logic [31:0] wr_data;
  logic        rd_en;
  logic [31:0] rd_data;
  logic        busy;
  logic        ack;

  modport master (output addr, be, wr_en, wr_data, rd_en,
                  input  rd_data, busy, ack);
  modport slave  (input  addr, be, wr_en, wr_data, rd_en,
                  output rd_data, busy, ack);
endinterface

// File: rtl/mem_bus_ram_array.sv
// Single-port byte-enabled RAM with a registered read-before-write output.
module mem_bus_ram_array #(
  parameter int DEPTH_LOG2 = 10
) (
  input  logic                  clk,
  input  logic                  reset_n,
  input  logic                  en,
  input  logic                  we,
  input  logic [3:0]            be,
  input  logic [DEPTH_LOG2-1:0] addr,
  input  logic [31:0]           wdata,
  output logic [31:0]           rdata
);

  logic [31:0] mem [2**DEPTH_LOG2];

  always_ff @(posedge clk) begin
    if (en && we) begin
      for (int i = 0; i < 4; i++) begin
        if (be[i]) mem[addr][8*i +: 8] <= wdata[8*i +: 8];
      end
    end
  end

  // Output register only moves on an access, so it holds between acks.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) rdata <= 32'h0;
    else if (en)  rdata <= mem[addr];
  end

endmodule

// File: rtl/mem_bus_ram_slave.sv
// mem_bus RAM responder: window decode, request capture, wait-state FSM.
module mem_bus_ram_slave
  import pck_mem_bus_ram::*;
#(
  parameter logic [31:0] BASE_ADDR   = 32'h0000_0000,
  parameter int          DEPTH_LOG2  = 10,
  parameter int          WAIT_CYCLES = 0
) (
  input  logic  clk,
  input  logic  reset_n,
  mem_bus.slave bus
);

  localparam logic [RAM_CNT_W-1:0] CNT_LOAD =
    (WAIT_CYCLES > 0) ? RAM_CNT_W'(WAIT_CYCLES - 1) : '0;
  localparam logic NO_WAIT = (WAIT_CYCLES == 0);

  ram_state_t            state, state_next;
  logic [RAM_CNT_W-1:0]  cnt;
  logic                  request, accept;
  logic [DEPTH_LOG2-1:0] cap_idx;
  logic [3:0]            cap_be;
  logic                  cap_we;
  logic [31:0]           cap_wdata;
  logic                  mem_en, mem_we;
  logic [3:0]            mem_be;
  logic [DEPTH_LOG2-1:0] mem_idx;
  logic [31:0]           mem_wdata, ram_rdata;

  assign request = (bus.rd_en | bus.wr_en) && in_window(bus.addr, BASE_ADDR, DEPTH_LOG2);
  assign accept  = request && reset_n && (state == IDLE || state == ACK);

  always_comb begin
    state_next = state;
    case (state)
      IDLE, ACK: state_next = accept ? (NO_WAIT ? ACK : WAIT) : IDLE;
      WAIT:      if (cnt == '0) state_next = ACK;
      default:   state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) state <= IDLE;
    else          state <= state_next;
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n)                         cnt <= '0;
    else if (accept)                      cnt <= CNT_LOAD;
    else if (state == WAIT && cnt != '0)  cnt <= cnt - 1'b1;
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      cap_idx   <= '0;
      cap_be    <= '0;
      cap_we    <= 1'b0;
      cap_wdata <= '0;
    end else if (accept) begin
      cap_idx   <= bus.addr[DEPTH_LOG2+1:2];
      cap_be    <= bus.be;
      cap_we    <= bus.wr_en;
      cap_wdata <= bus.wr_data;
    end
  end

  // The RAM fires on the ACK-entry edge; without wait states that is the
  // accepting edge itself, so the live bus feeds it instead of the captures.
  assign mem_en    = NO_WAIT ? accept : (state == WAIT && cnt == '0);
  assign mem_we    = NO_WAIT ? bus.wr_en : cap_we;
  assign mem_be    = NO_WAIT ? bus.be : cap_be;
  assign mem_idx   = NO_WAIT ? bus.addr[DEPTH_LOG2+1:2] : cap_idx;
  assign mem_wdata = NO_WAIT ? bus.wr_data : cap_wdata;

  mem_bus_ram_array #(.DEPTH_LOG2(DEPTH_LOG2)) u_array (
    .clk     (clk),
    .reset_n (reset_n),
    .en      (mem_en),
    .we      (mem_we),
    .be      (mem_be),
    .addr    (mem_idx),
    .wdata   (mem_wdata),
    .rdata   (ram_rdata)
  );

  assign bus.rd_data = ram_rdata;
  assign bus.busy    = (state == WAIT);
  assign bus.ack     = (state == ACK);

endmodule

// File: tb/tb_mem_bus_ram_slave.sv
// Directed bench for mem_bus_ram_slave at WAIT_CYCLES = 0, 3 and 2.
module tb_mem_bus_ram_slave;

  logic        clk;
  logic        t_rst   [3];
  logic [31:0] t_addr  [3];
  logic [3:0]  t_be    [3];
  logic        t_wr    [3];
  logic        t_rd    [3];
  logic [31:0] t_wdata [3];

  int checks   = 0;
  int failures = 0;

  mem_bus bus0 ();
  mem_bus bus1 ();
  mem_bus bus2 ();

  assign bus0.addr = t_addr[0];  assign bus0.be = t_be[0];  assign bus0.wr_en = t_wr[0];
  assign bus0.rd_en = t_rd[0];   assign bus0.wr_data = t_wdata[0];
  assign bus1.addr = t_addr[1];  assign bus1.be = t_be[1];  assign bus1.wr_en = t_wr[1];
  assign bus1.rd_en = t_rd[1];   assign bus1.wr_data = t_wdata[1];
  assign bus2.addr = t_addr[2];  assign bus2.be = t_be[2];  assign bus2.wr_en = t_wr[2];
  assign bus2.rd_en = t_rd[2];   assign bus2.wr_data = t_wdata[2];

  mem_bus_ram_slave #(.WAIT_CYCLES(0)) dut0 (.clk(clk), .reset_n(t_rst[0]), .bus(bus0));
  mem_bus_ram_slave #(.WAIT_CYCLES(3)) dut1 (.clk(clk), .reset_n(t_rst[1]), .bus(bus1));
  mem_bus_ram_slave #(.WAIT_CYCLES(2)) dut2 (.clk(clk), .reset_n(t_rst[2]), .bus(bus2));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic get_busy(input int idx);
    case (idx)
      0:       return bus0.busy;
      1:       return bus1.busy;
      default: return bus2.busy;
    endcase
  endfunction

  function automatic logic get_ack(input int idx);
    case (idx)
      0:       return bus0.ack;
      1:       return bus1.ack;
      default: return bus2.ack;
    endcase
  endfunction

  function automatic logic [31:0] get_rdata(input int idx);
    case (idx)
      0:       return bus0.rd_data;
      1:       return bus1.rd_data;
      default: return bus2.rd_data;
    endcase
  endfunction

  task automatic check_output(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("[TB] FAIL %s got=%h expected=%h", tag, got, exp);
    end
  endtask

  task automatic drive(input int idx, input logic rd, input logic wr,
                       input logic [31:0] a, input logic [3:0] be, input logic [31:0] d);
    t_rd[idx] = rd;  t_wr[idx] = wr;  t_addr[idx] = a;  t_be[idx] = be;  t_wdata[idx] = d;
  endtask

  task automatic set_idle(input int idx);
    t_rd[idx] = 1'b0;
    t_wr[idx] = 1'b0;
  endtask

  // One-cycle request, then watch until ack (bounded); lat counts cycles after acceptance.
  task automatic apply_stimulus(input int idx, input logic rd, input logic wr,
                                input logic [31:0] a, input logic [3:0] be, input logic [31:0] d,
                                output logic [31:0] rdata, output int lat, output int nbusy);
    @(negedge clk);
    drive(idx, rd, wr, a, be, d);
    lat = -1;  nbusy = 0;  rdata = 32'h0;
    for (int k = 1; k <= 30; k++) begin
      @(negedge clk);
      if (k == 1) set_idle(idx);
      if (get_busy(idx)) nbusy++;
      if (get_ack(idx)) begin
        lat   = k;
        rdata = get_rdata(idx);
        break;
      end
    end
    set_idle(idx);
  endtask

  logic [31:0] rdata;
  int lat, nbusy, cnt;

  initial begin
    for (int i = 0; i < 3; i++) begin
      t_rst[i] = 1'b0;
      drive(i, 1'b0, 1'b0, 32'h0, 4'h0, 32'h0);
    end
    repeat (3) @(negedge clk);
    check_output("rst_busy0",  32'(get_busy(0)), 32'h0);
    check_output("rst_ack0",   32'(get_ack(0)),  32'h0);
    check_output("rst_rdata0", get_rdata(0),     32'h0);
    check_output("rst_busy1",  32'(get_busy(1)), 32'h0);
    for (int i = 0; i < 3; i++) t_rst[i] = 1'b1;

    // WAIT_CYCLES = 0
    apply_stimulus(0, 1'b0, 1'b1, 32'h10, 4'hF, 32'hDEAD_BEEF, rdata, lat, nbusy);
    check_output("w0_wr_lat", lat, 1);
    check_output("w0_wr_busy", nbusy, 0);
    apply_stimulus(0, 1'b1, 1'b0, 32'h10, 4'hF, 32'h0, rdata, lat, nbusy);
    check_output("w0_rd_lat", lat, 1);
    check_output("w0_rd_busy", nbusy, 0);
    check_output("w0_rd_data", rdata, 32'hDEAD_BEEF);

    apply_stimulus(0, 1'b0, 1'b1, 32'h10, 4'hF, 32'h1122_3344, rdata, lat, nbusy);
    apply_stimulus(0, 1'b0, 1'b1, 32'h10, 4'b0001, 32'h0000_00AA, rdata, lat, nbusy);
    apply_stimulus(0, 1'b1, 1'b0, 32'h10, 4'hF, 32'h0, rdata, lat, nbusy);
    check_output("w0_lane0", rdata, 32'h1122_33AA);

    apply_stimulus(0, 1'b0, 1'b1, 32'h10, 4'h0, 32'hFFFF_FFFF, rdata, lat, nbusy);
    check_output("be0_lat", lat, 1);
    apply_stimulus(0, 1'b1, 1'b0, 32'h10, 4'hF, 32'h0, rdata, lat, nbusy);
    check_output("be0_data", rdata, 32'h1122_33AA);

    apply_stimulus(0, 1'b0, 1'b1, 32'h20, 4'hF, 32'h0, rdata, lat, nbusy);
    apply_stimulus(0, 1'b1, 1'b1, 32'h20, 4'hF, 32'h5555_5555, rdata, lat, nbusy);
    check_output("rw_lat", lat, 1);
    check_output("rw_old", rdata, 32'h0);
    apply_stimulus(0, 1'b1, 1'b0, 32'h20, 4'hF, 32'h0, rdata, lat, nbusy);
    check_output("rw_new", rdata, 32'h5555_5555);

    // Write immediately followed by a read issued in the ack cycle
    @(negedge clk);
    drive(0, 1'b0, 1'b1, 32'h50, 4'hF, 32'hA5A5_0F0F);
    @(negedge clk);
    check_output("b2b_wr_ack", 32'(get_ack(0)), 32'h1);
    drive(0, 1'b1, 1'b0, 32'h50, 4'hF, 32'h0);
    @(negedge clk);
    check_output("b2b_rd_ack", 32'(get_ack(0)), 32'h1);
    check_output("b2b_rd_data", get_rdata(0), 32'hA5A5_0F0F);
    set_idle(0);

    // Out of window, held for 20 cycles
    @(negedge clk);
    drive(0, 1'b1, 1'b0, 32'h1000, 4'hF, 32'h0);
    cnt = 0;
    repeat (20) begin
      @(negedge clk);
      if (get_busy(0) || get_ack(0)) cnt++;
    end
    set_idle(0);
    check_output("oow_quiet", cnt, 0);
    apply_stimulus(0, 1'b1, 1'b0, 32'h4, 4'hF, 32'h0, rdata, lat, nbusy);
    check_output("oow_then_lat", lat, 1);

    // WAIT_CYCLES = 3
    apply_stimulus(1, 1'b0, 1'b1, 32'h30, 4'hF, 32'hCAFE_F00D, rdata, lat, nbusy);
    check_output("w3_wr_lat", lat, 4);
    apply_stimulus(1, 1'b1, 1'b0, 32'h30, 4'hF, 32'h0, rdata, lat, nbusy);
    check_output("w3_rd_lat", lat, 4);
    check_output("w3_rd_busy", nbusy, 3);
    check_output("w3_rd_data", rdata, 32'hCAFE_F00D);

    @(negedge clk);
    drive(1, 1'b1, 1'b0, 32'h30, 4'hF, 32'h0);
    @(negedge clk);
    check_output("w3_busy_n1", 32'(get_busy(1)), 32'h1);
    drive(1, 1'b1, 1'b0, 32'h34, 4'hF, 32'h0);
    @(negedge clk);
    set_idle(1);
    cnt = 0;
    rdata = 32'h0;
    repeat (12) begin
      if (get_ack(1)) begin
        cnt++;
        rdata = get_rdata(1);
      end
      @(negedge clk);
    end
    check_output("w3_ign_acks", cnt, 1);
    check_output("w3_ign_data", rdata, 32'hCAFE_F00D);

    // WAIT_CYCLES = 2, reset during WAIT of a write
    apply_stimulus(2, 1'b0, 1'b1, 32'h40, 4'hF, 32'h1234_5678, rdata, lat, nbusy);
    check_output("w2_wr_lat", lat, 3);
    check_output("w2_wr_busy", nbusy, 2);
    apply_stimulus(2, 1'b1, 1'b0, 32'h40, 4'hF, 32'h0, rdata, lat, nbusy);
    check_output("w2_rd_data", rdata, 32'h1234_5678);

    @(negedge clk);
    drive(2, 1'b0, 1'b1, 32'h40, 4'hF, 32'h8765_4321);
    @(negedge clk);
    check_output("w2_busy_pre", 32'(get_busy(2)), 32'h1);
    set_idle(2);
    #2 t_rst[2] = 1'b0;
    #1;
    check_output("rst_mid_busy",  32'(get_busy(2)), 32'h0);
    check_output("rst_mid_ack",   32'(get_ack(2)),  32'h0);
    check_output("rst_mid_rdata", get_rdata(2),     32'h0);
    cnt = 0;
    repeat (4) begin
      @(negedge clk);
      if (get_ack(2)) cnt++;
    end
    check_output("rst_mid_noack", cnt, 0);
    t_rst[2] = 1'b1;
    apply_stimulus(2, 1'b1, 1'b0, 32'h40, 4'hF, 32'h0, rdata, lat, nbusy);
    check_output("rst_lost_lat", lat, 3);
    check_output("rst_lost_data", rdata, 32'h1234_5678);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
